// File: rtl/led_stretch_sched_if.sv
// Signal bundle between the board switch/LED path and the stretch scheduler.
// There is no handshake here: inputs are level-sampled on every clock, and outputs are registered levels.
interface led_stretch_sched_if #(
    parameter int NCH = 4,
    parameter int TW  = 12
);
    logic                    i_en;
    logic [NCH-1:0]          i_sw;
    logic [TW-1:0]           i_len;
    logic [NCH-1:0]          o_led;
    logic                    o_tick;
    logic                    o_busy;
    // Per-channel FSM state and tick counter, exposed for observation only
    logic [NCH-1:0][1:0]     dbg_state;
    logic [NCH-1:0][TW-1:0]  dbg_cnt;

    modport master (
        output i_en, i_sw, i_len,
        input  o_led, o_tick, o_busy, dbg_state, dbg_cnt
    );

    modport slave (
        input  i_en, i_sw, i_len,
        output o_led, o_tick, o_busy, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/led_stretch_sched.sv
// Multi-channel LED pulse stretcher: each LED follows its switch, then stays lit for
// i_len prescaled ticks after release. One shared prescaler drives every channel's timer.
module led_stretch_sched #(
    parameter int NCH      = 4,
    parameter int PRESCALE = 100000,
    parameter int TW       = 12
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    led_stretch_sched_if.slave bus
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HELD    = 2'd1,
        ST_STRETCH = 2'd2
    } state_e;

    logic [NCH-1:0] sw_meta_q;
    logic [NCH-1:0] sw_s_q;
    logic [PW-1:0]  pcnt_q;
    logic [PW-1:0]  pcnt_d;
    logic           tick_q;
    logic           tick_d;

    state_e         state_q [NCH];
    state_e         state_d [NCH];
    logic [TW-1:0]  cnt_q   [NCH];
    logic [TW-1:0]  cnt_d   [NCH];

    logic [NCH-1:0]          led_w;
    logic [NCH-1:0][1:0]     dbg_state_w;
    logic [NCH-1:0][TW-1:0]  dbg_cnt_w;

    // Synchronizers stay live while disabled so re-enable sees current switch levels
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_meta_q <= '0;
            sw_s_q    <= '0;
        end else begin
            sw_meta_q <= bus.i_sw;
            sw_s_q    <= sw_meta_q;
        end
    end

    always_comb begin
        pcnt_d = pcnt_q;
        tick_d = 1'b0;
        if (!bus.i_en) begin
            pcnt_d = '0;
        end else if (pcnt_q == PCNT_MAX) begin
            pcnt_d = '0;
            tick_d = 1'b1;
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Retrigger beats the tick; the count is only decremented while it is at least 1
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!bus.i_en) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (sw_s_q[i]) state_d[i] = ST_HELD;
                    end
                    ST_HELD: begin
                        if (!sw_s_q[i]) begin
                            if (bus.i_len != '0) begin
                                state_d[i] = ST_STRETCH;
                                cnt_d[i]   = bus.i_len;
                            end else begin
                                state_d[i] = ST_IDLE;
                            end
                        end
                    end
                    ST_STRETCH: begin
                        if (sw_s_q[i]) begin
                            state_d[i] = ST_HELD;
                        end else if (tick_q) begin
                            if (cnt_q[i] <= TW'(1)) begin
                                state_d[i] = ST_IDLE;
                                cnt_d[i]   = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] - TW'(1);
                            end
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        led_w       = '0;
        dbg_state_w = '0;
        dbg_cnt_w   = '0;
        for (int i = 0; i < NCH; i++) begin
            led_w[i]       = (state_q[i] != ST_IDLE);
            dbg_state_w[i] = state_q[i];
            dbg_cnt_w[i]   = cnt_q[i];
        end
    end

    assign bus.o_led     = led_w;
    assign bus.o_busy    = |led_w;
    assign bus.o_tick    = tick_q;
    assign bus.dbg_state = dbg_state_w;
    assign bus.dbg_cnt   = dbg_cnt_w;

endmodule

// File: tb/tb_led_stretch_sched.sv
// Directed bench for led_stretch_sched with a short prescaler: latency, stretch length,
// retrigger, zero length, length change mid-stretch, all-channel, enable drop and async reset.
module tb_led_stretch_sched;

    localparam int NCH      = 4;
    localparam int PRESCALE = 4;
    localparam int TW       = 12;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HELD    = 2'd1;
    localparam logic [1:0] S_STRETCH = 2'd2;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;

    led_stretch_sched_if #(.NCH(NCH), .TW(TW)) bus ();

    led_stretch_sched #(
        .NCH      (NCH),
        .PRESCALE (PRESCALE),
        .TW       (TW)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    // ---------------- clock / watchdog ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [NCH-1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Apply a switch vector, then check o_led after each of the next three edges
    task automatic sw_expect(input logic [NCH-1:0] sw_val, input logic [NCH-1:0] led_mid,
                             input logic [NCH-1:0] led_end, input string tag);
        exp_q.push_back(led_mid);
        exp_q.push_back(led_mid);
        exp_q.push_back(led_end);
        bus.i_sw = sw_val;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq($sformatf("%s_led_e%0d", tag, k + 1), 32'(bus.o_led), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic check_entry(input logic [NCH-1:0] mask, input int len, input string tag);
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                check_eq($sformatf("%s_state%0d", tag, c), 32'(bus.dbg_state[c]), 32'(S_STRETCH));
                check_eq($sformatf("%s_cnt%0d", tag, c), 32'(bus.dbg_cnt[c]), 32'(len));
            end
        end
    endtask

    // From just after stretch entry: LEDs in mask stay lit until the edge consuming tick #len
    task automatic run_stretch(input logic [NCH-1:0] mask, input int len, input string tag);
        int ticks;
        int cyc;
        logic tk;
        logic [NCH-1:0] exp_led;
        ticks = 0;
        cyc   = 0;
        while (ticks < len && cyc < len * PRESCALE + PRESCALE + 4) begin
            tk = bus.o_tick;
            step();
            cyc++;
            if (tk) ticks++;
            exp_led = (ticks < len) ? mask : '0;
            check_eq($sformatf("%s_led_c%0d", tag, cyc), 32'(bus.o_led), 32'(exp_led));
            check_eq($sformatf("%s_busy_c%0d", tag, cyc), 32'(bus.o_busy), 32'(|exp_led));
            for (int c = 0; c < NCH; c++) begin
                if (mask[c])
                    check_eq($sformatf("%s_cnt%0d_c%0d", tag, c, cyc), 32'(bus.dbg_cnt[c]),
                             32'((ticks < len) ? (len - ticks) : 0));
            end
        end
        check_eq($sformatf("%s_ticks", tag), 32'(ticks), 32'(len));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int ticks;
        logic tk;

        bus.i_en  = 1'b0;
        bus.i_sw  = '0;
        bus.i_len = '0;
        #2 i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_eq("rst_led", 32'(bus.o_led), 32'h0);
        check_eq("rst_tick", 32'(bus.o_tick), 32'h0);
        check_eq("rst_busy", 32'(bus.o_busy), 32'h0);
        for (int c = 0; c < NCH; c++) begin
            check_eq($sformatf("rst_cnt%0d", c), 32'(bus.dbg_cnt[c]), 32'h0);
            check_eq($sformatf("rst_state%0d", c), 32'(bus.dbg_state[c]), 32'(S_IDLE));
        end
        i_rst_n = 1'b1;
        bus.i_en = 1'b1;

        // Tick period: consecutive ticks PRESCALE clocks apart
        cyc = 0;
        while (bus.o_tick !== 1'b1 && cyc < 2 * PRESCALE + 2) begin step(); cyc++; end
        check_eq("tick_first_seen", 32'(bus.o_tick), 32'h1);
        step();
        check_eq("tick_one_cycle", 32'(bus.o_tick), 32'h0);
        cyc = 1;
        while (bus.o_tick !== 1'b1 && cyc < 2 * PRESCALE + 2) begin step(); cyc++; end
        check_eq("tick_period", 32'(cyc), 32'(PRESCALE));

        // 1: ch0, len 3, held 10 clocks
        bus.i_len = 12'd3;
        sw_expect(4'b0001, 4'b0000, 4'b0001, "t1_press");
        repeat (7) begin
            step();
            check_eq("t1_held_led", 32'(bus.o_led), 32'h1);
        end
        sw_expect(4'b0000, 4'b0001, 4'b0001, "t1_rel");
        check_entry(4'b0001, 3, "t1_entry");
        run_stretch(4'b0001, 3, "t1_str");

        // 2: ch1 retrigger after first tick
        sw_expect(4'b0010, 4'b0000, 4'b0010, "t2_press");
        sw_expect(4'b0000, 4'b0010, 4'b0010, "t2_rel");
        check_entry(4'b0010, 3, "t2_entry");
        ticks = 0;
        cyc   = 0;
        while (ticks == 0 && cyc < 2 * PRESCALE + 2) begin
            tk = bus.o_tick;
            step();
            cyc++;
            if (tk) ticks++;
            check_eq("t2_wait_led", 32'(bus.o_led), 32'h2);
        end
        check_eq("t2_cnt_after_tick", 32'(bus.dbg_cnt[1]), 32'd2);
        bus.i_len = 12'd5;
        sw_expect(4'b0010, 4'b0010, 4'b0010, "t2_retrig");
        check_eq("t2_retrig_state", 32'(bus.dbg_state[1]), 32'(S_HELD));
        step();
        sw_expect(4'b0000, 4'b0010, 4'b0010, "t2_rel2");
        check_entry(4'b0010, 5, "t2_entry2");
        run_stretch(4'b0010, 5, "t2_str");

        // 3: ch2, len 0: no stretch
        bus.i_len = 12'd0;
        sw_expect(4'b0100, 4'b0000, 4'b0100, "t3_press");
        step();
        sw_expect(4'b0000, 4'b0100, 4'b0000, "t3_rel");
        check_eq("t3_state", 32'(bus.dbg_state[2]), 32'(S_IDLE));
        check_eq("t3_cnt", 32'(bus.dbg_cnt[2]), 32'd0);

        // 4: ch3, length changes mid-stretch
        bus.i_len = 12'd3;
        sw_expect(4'b1000, 4'b0000, 4'b1000, "t4_press");
        sw_expect(4'b0000, 4'b1000, 4'b1000, "t4_rel");
        check_entry(4'b1000, 3, "t4_entry");
        bus.i_len = 12'd7;
        run_stretch(4'b1000, 3, "t4_str");
        sw_expect(4'b1000, 4'b0000, 4'b1000, "t4_press2");
        sw_expect(4'b0000, 4'b1000, 4'b1000, "t4_rel2");
        check_entry(4'b1000, 7, "t4_entry2");
        run_stretch(4'b1000, 7, "t4_str2");

        // 5: all channels together, len 2
        bus.i_len = 12'd2;
        sw_expect(4'b1111, 4'b0000, 4'b1111, "t5_press");
        check_eq("t5_busy", 32'(bus.o_busy), 32'h1);
        sw_expect(4'b0000, 4'b1111, 4'b1111, "t5_rel");
        check_entry(4'b1111, 2, "t5_entry");
        run_stretch(4'b1111, 2, "t5_str");

        // 6a: enable dropped for one clock on the edge that would raise o_tick
        bus.i_len = 12'd3;
        sw_expect(4'b0001, 4'b0000, 4'b0001, "t6_press");
        sw_expect(4'b0000, 4'b0001, 4'b0001, "t6_rel");
        cyc = 0;
        while (bus.o_tick !== 1'b1 && cyc < 2 * PRESCALE + 2) begin step(); cyc++; end
        check_eq("t6_sync_tick", 32'(bus.o_tick), 32'h1);
        repeat (PRESCALE - 1) step();
        check_eq("t6_pre_led", 32'(bus.o_led), 32'h1);
        bus.i_en = 1'b0;
        step();
        check_eq("t6_en_led", 32'(bus.o_led), 32'h0);
        check_eq("t6_en_tick", 32'(bus.o_tick), 32'h0);
        check_eq("t6_en_busy", 32'(bus.o_busy), 32'h0);
        check_eq("t6_en_cnt", 32'(bus.dbg_cnt[0]), 32'h0);
        check_eq("t6_en_state", 32'(bus.dbg_state[0]), 32'(S_IDLE));
        bus.i_en = 1'b1;
        step();
        check_eq("t6_reen_tick", 32'(bus.o_tick), 32'h0);
        check_eq("t6_reen_led", 32'(bus.o_led), 32'h0);

        // 6b: asynchronous reset mid-stretch
        sw_expect(4'b0001, 4'b0000, 4'b0001, "t6b_press");
        sw_expect(4'b0000, 4'b0001, 4'b0001, "t6b_rel");
        check_entry(4'b0001, 3, "t6b_entry");
        #2 i_rst_n = 1'b0;
        #1;
        check_eq("t6b_rst_led", 32'(bus.o_led), 32'h0);
        check_eq("t6b_rst_busy", 32'(bus.o_busy), 32'h0);
        check_eq("t6b_rst_tick", 32'(bus.o_tick), 32'h0);
        check_eq("t6b_rst_cnt", 32'(bus.dbg_cnt[0]), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        step();
        check_eq("t6b_post_led", 32'(bus.o_led), 32'h0);
        for (int c = 0; c < NCH; c++) begin
            check_eq($sformatf("t6b_post_cnt%0d", c), 32'(bus.dbg_cnt[c]), 32'h0);
            check_eq($sformatf("t6b_post_state%0d", c), 32'(bus.dbg_state[c]), 32'(S_IDLE));
        end

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_stretch_sched.md
Name: led_stretch_sched

Overview:
- Multi-channel pulse-stretch controller for the board's switch/LED path.
- Each switch channel drives one LED: the LED is lit while the switch is held, then stays lit for a programmable number of prescaled ticks after release.
- A single shared prescaler sequences every channel's stretch timer.
- Sits between the raw board switches and the LED pins, and replaces the per-LED free-running stretch counters.

Parameters:
- NCH, 4, number of switch/LED channels.
- PRESCALE, 100000, clocks per stretch tick (>=2).
- TW, 12, width of the stretch-length field and of each channel's tick counter.

Ports:
- i_clk  input  1  system clock; all state on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_en  input  1  global enable; 0 forces all channels idle.
- i_sw  input  NCH  raw asynchronous switch inputs, active high.
- i_len  input  TW  stretch length in ticks; sampled per channel on release.
- o_led  output  NCH  LED drive, 1 = lit.
- o_tick  output  1  one-clock pulse at each prescaler wrap.
- o_busy  output  1  OR of o_led.

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - Synchronizers, prescaler and tick counters go to 0; all FSMs go to IDLE.
  - o_led=0, o_tick=0, o_busy=0.
  - Deassertion takes effect on the next rising edge.
- Synchronizer: two-flop synchronizer per i_sw bit; FSMs see only sw_s (second flop).
- Prescaler:
  - pcnt counts 0..PRESCALE-1 and wraps to 0.
  - o_tick is registered, high for the one cycle after pcnt==PRESCALE-1.
  - While i_en=0, pcnt is held at 0 and o_tick is 0.
- Per-channel FSM (state and cnt[TW-1:0] registered), evaluated each edge when i_en=1:
  - IDLE: sw_s=1 -> HELD; otherwise stay.
  - HELD: sw_s=0 and i_len!=0 -> STRETCH, cnt<=i_len. sw_s=0 and i_len==0 -> IDLE. Otherwise stay.
  - STRETCH, sw_s=1 -> HELD. This retrigger has priority over the tick.
  - STRETCH, sw_s=0 and o_tick=1: if cnt==1 -> IDLE, cnt<=0; else cnt<=cnt-1.
  - STRETCH, no tick: hold.
- i_len is sampled only on the HELD->STRETCH edge. Later changes do not affect a running stretch.
- Stretch duration is exactly i_len ticks counted after entry. The first tick may arrive after 1..PRESCALE clocks.
- i_en=0: every channel is synchronously forced to IDLE with cnt=0 on that edge. Synchronizers keep running.
- Outputs:
  - o_led[i] = (state_i != IDLE), decoded from registered state, no combinational path from i_sw.
  - o_busy = |o_led.
- Latency:
  - i_sw rising, stable before edge k -> o_led high after edge k+2.
  - Release to stretch entry is likewise 3 edges.
- Counters never wrap: cnt is only decremented while >=1. cnt is TW bits, so i_len max = 2^TW-1 ticks.
- Channels are fully independent; simultaneous presses or releases on several channels are each handled in the same cycle.
- Reset asserted mid-stretch clears immediately (asynchronously): LED off, no residual count.

Test Plan:
1. PRESCALE=4, i_len=3: pulse i_sw[0] high for 10 clocks, then low.
   -> o_led[0] rises 3 edges after the press and stays lit while held.
   -> After release it stays lit for 3 o_tick pulses, dropping on the edge that consumes the third tick.
   -> o_led[3:1]=0 throughout.
2. Retrigger: release sw[1], then re-press before the 2nd tick.
   -> Channel returns to HELD and the LED never drops.
   -> On the next release, cnt reloads the current i_len; total stretch again equals i_len ticks.
3. i_len=0: press then release sw[2] -> o_led[2] falls 3 edges after the release; no STRETCH state entered.
4. Change i_len from 3 to 7 mid-stretch on ch3 -> stretch still ends after 3 ticks; the next release uses 7.
5. All four switches pressed and released on the same cycle, i_len=2.
   -> All LEDs rise together and fall together after 2 ticks.
   -> o_busy mirrors the OR of the LEDs.
6. Mid-stretch disturbances:
   -> Drop i_en for 1 clock: all LEDs go 0 on that edge and o_tick is suppressed.
   -> Assert i_rst_n=0 asynchronously between edges: o_led clears immediately, and the counters read 0 after release.
